// File: rtl/enable_capture_arbiter.sv
// Round-robin owner of one shared enable-gated capture register.
// Each grant loads the winner's data and keeps it valid for HOLD_CYCLES cycles.
module enable_capture_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic [ID_W-1:0]           owner_id,
  output logic                      busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic [ID_W-1:0]    owner_id_q, owner_id_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    cand;
  int                 idx;

  // Search starts at ptr and wraps modulo NUM_REQ; first pending requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    owner_id_d   = owner_id_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d      = HOLD;
          gnt_d        = NUM_REQ'(1) << win_idx;
          data_out_d   = req_data[int'(win_idx)*DATA_W +: DATA_W];
          owner_id_d   = win_idx;
          data_valid_d = 1'b1;
          hold_cnt_d   = 8'(HOLD_CYCLES - 1);
          ptr_d        = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      default: begin
        // Requests are ignored here, so grants can never be back-to-back.
        if (hold_cnt_q != 8'd0) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end else begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 8'd0;
      ptr_q        <= '0;
      gnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      owner_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      owner_id_q   <= owner_id_d;
    end
  end

  assign gnt        = gnt_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign owner_id   = owner_id_q;
  assign busy       = (state_q == HOLD);

endmodule

// File: doc/enable_capture_arbiter.md
# enable_capture_arbiter

Round-robin scheduler that shares one clock-enabled capture register among several requesters. It picks one pending requester and drives the shared register's enable with that requester's data. It then holds the captured value valid for a fixed number of cycles and acknowledges the winner with a one-cycle grant. It sits in front of enable-gated datapath registers, so the clock is only ever used as a clock and all gating is done through a data-path enable.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- DATA_W, default 8: width of each requester's data and of the shared register.
- HOLD_CYCLES, default 2: number of cycles data_valid stays high per grant; legal range 1..255; 0 is illegal.
- ID_W, default $clog2(NUM_REQ): width of owner_id; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
- data_out  output  DATA_W  shared capture register.
- data_valid  output  1  high while the captured value is in its hold window.
- owner_id  output  ID_W  index of the most recent winner.
- busy  output  1  high whenever state is HOLD.

## Operation
- Two states, IDLE and HOLD. State and all outputs are registers.
- IDLE, no req bit set: remain in IDLE and leave all registers unchanged except gnt, which is 0.
- IDLE, any req bit set: select a winner w by round-robin. The search starts at index ptr and wraps modulo NUM_REQ. At the clock edge:
  - state <= HOLD
  - gnt <= one-hot(w)
  - data_out <= req_data[w] (this is the enable-gated capture)
  - owner_id <= w
  - data_valid <= 1
  - hold_cnt <= HOLD_CYCLES-1
  - ptr <= (w+1) mod NUM_REQ
- HOLD: gnt <= 0; req is ignored.
  - If hold_cnt != 0: hold_cnt decrements.
  - If hold_cnt == 0: state <= IDLE and data_valid <= 0.
- data_out and owner_id are written only on a grant. They keep their value through IDLE.
- HOLD always exits to IDLE. There are no back-to-back grants.
- A requester whose req is still high in the IDLE cycle after its hold window is treated as a new request. Requesters deassert req on the edge after they see gnt.
- req_data[w] must be stable in the cycle where IDLE samples req.
- busy = (state == HOLD).

## Timing
- Reset (asynchronous assert, any cycle, including mid-HOLD): state = IDLE, gnt = 0, data_out = 0, data_valid = 0, owner_id = 0, busy = 0, hold_cnt = 0, ptr = 0. Reset release is synchronous to clk; the first grant is possible on the first edge after release.
- Latency: a req sampled at edge E produces gnt, data_out, data_valid and busy visible after edge E.
- data_valid is high for exactly HOLD_CYCLES cycles; gnt is high for exactly 1 cycle, the first of those.
- Throughput: at most one grant per HOLD_CYCLES+1 cycles.
- After reset, priority is req[0] > req[1] > ... on the first arbitration.
- Wrap-around: after granting NUM_REQ-1, the search starts at index 0.
- Simultaneous requests: exactly one gnt bit is ever set. Losers keep waiting with no starvation; a constantly asserted requester waits at most NUM_REQ-1 grants.
- hold_cnt width is 8 bits.

## Test plan
All scenarios use NUM_REQ=4, DATA_W=8, HOLD_CYCLES=2.
- Reset: assert rst_n=0 mid-HOLD -> all outputs 0 in the same cycle, without waiting for an edge; after release with req=0, outputs stay 0.
- Single request: req=4'b0100, req_data[2]=8'hA5 -> next cycle gnt=4'b0100, data_out=8'hA5, owner_id=2, data_valid=1; data_valid=1 for 2 cycles then 0; data_out stays 8'hA5.
- All request continuously: req=4'b1111 held -> grants in order 0,1,2,3,0, each gnt pulse exactly 3 cycles apart; no two gnt bits set at once.
- Requests during HOLD are ignored: req[1] rises during a hold window -> no gnt until that window ends; the grant then occurs after the IDLE edge.
- Wrap-around: after a grant to 3, req=4'b1001 -> grant to 0 (the search starts at 0), then the next grant goes to 3.
- data_out stability: after a grant, change req_data while req=0 -> data_out and owner_id unchanged.
